// File: rtl/pc_sequencer_pkg.sv
// Shared types and default widths for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_OFFSET_W = 8;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_ISTALL = 2'd2,
        ST_DSTALL = 2'd3
    } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: PC+4 or PC-relative jump/branch target.
module pc_next_calc #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 8
) (
    input  logic [ADDR_W-1:0]   pc,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                jump,
    input  logic                branch,
    input  logic                zero,
    output logic [ADDR_W-1:0]   next_pc
);

    logic              taken;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] off_ext;

    // Word offset becomes a byte offset; all arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        taken   = jump | (branch & zero);
        pc4     = pc + ADDR_W'(4);
        off_ext = {{(ADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
        next_pc = taken ? (pc4 + (off_ext << 2)) : pc4;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer with stall handling and saturating counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned      ADDR_W   = DEF_ADDR_W,
    parameter int unsigned      OFFSET_W = DEF_OFFSET_W,
    parameter int unsigned      CNT_W    = DEF_CNT_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jump,
    input  logic                branch,
    input  logic                zero,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                ibusy,
    input  logic                dbusy,
    output logic [ADDR_W-1:0]   pc,
    output logic                fetch_req,
    output logic                retire,
    output logic [CNT_W-1:0]    retired,
    output logic [CNT_W-1:0]    stalls
);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] next_pc;
    logic              stall_c;

    pc_next_calc #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) u_next (
        .pc      (pc),
        .offset  (offset),
        .jump    (jump),
        .branch  (branch),
        .zero    (zero),
        .next_pc (next_pc)
    );

    // A data stall outranks an instruction stall: the current instruction cannot complete.
    always_comb begin
        state_n = state;
        retire  = 1'b0;
        stall_c = 1'b0;
        case (state)
            ST_BOOT: state_n = ST_RUN;
            ST_RUN: begin
                if (dbusy) begin
                    state_n = ST_DSTALL;
                end else if (ibusy) begin
                    state_n = ST_ISTALL;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_ISTALL: begin
                stall_c = 1'b1;
                if (!ibusy) begin
                    state_n = ST_RUN;
                end
            end
            ST_DSTALL: begin
                stall_c = 1'b1;
                if (!dbusy && !ibusy) begin
                    state_n = ST_RUN;
                    retire  = 1'b1;
                end
            end
            default: state_n = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_BOOT;
            pc        <= RESET_PC;
            fetch_req <= 1'b0;
            retired   <= '0;
            stalls    <= '0;
        end else begin
            state     <= state_n;
            fetch_req <= (state_n == ST_RUN) || (state_n == ST_ISTALL);
            if (retire) begin
                pc <= next_pc;
            end
            if (retire && (retired != '1)) begin
                retired <= retired + CNT_W'(1);
            end
            if (stall_c && (stalls != '1)) begin
                stalls <= stalls + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expectations queued at drive time, checked after each edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, jump, branch, zero, ibusy, dbusy;
    logic [7:0]  offset;
    logic [31:0] pc;
    logic        fetch_req, retire;
    logic [15:0] retired, stalls;

    int total = 0;
    int bad   = 0;
    int step  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        fr;
        logic [15:0] retired;
        logic [15:0] stalls;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .jump      (jump),
        .branch    (branch),
        .zero      (zero),
        .offset    (offset),
        .ibusy     (ibusy),
        .dbusy     (dbusy),
        .pc        (pc),
        .fetch_req (fetch_req),
        .retire    (retire),
        .retired   (retired),
        .stalls    (stalls)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL step%0d %s observed=%h expected=%h", step, tag, obs, expv);
        end
    endtask

    // One clock: drive, check combinational retire, queue post-edge expectation, check after edge.
    task automatic tick(input logic r, input logic j, input logic b, input logic z,
                        input logic [7:0] off, input logic ib, input logic db,
                        input logic cr, input logic er,
                        input logic [31:0] epc, input logic efr,
                        input logic [15:0] ert, input logic [15:0] est);
        exp_t e;
        step++;
        reset = r; jump = j; branch = b; zero = z; offset = off; ibusy = ib; dbusy = db;
        #2;
        if (cr) chk("retire", 32'(retire), 32'(er));
        q.push_back('{pc: epc, fr: efr, retired: ert, stalls: est});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            chk("pc",        pc,             e.pc);
            chk("fetch_req", 32'(fetch_req), 32'(e.fr));
            chk("retired",   32'(retired),   32'(e.retired));
            chk("stalls",    32'(stalls),    32'(e.stalls));
        end
    endtask

    initial begin
        reset = 1'b1; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        offset = 8'h00; ibusy = 1'b0; dbusy = 1'b0;
        @(posedge clk); #1;

        // Reset, boot, then sequential fetch
        tick(1,0,0,0,8'h00,0,0, 0,0, 32'h0,  0, 16'd0, 16'd0);
        tick(1,0,0,0,8'h00,0,0, 1,0, 32'h0,  0, 16'd0, 16'd0);
        tick(0,0,0,0,8'h00,0,0, 1,0, 32'h0,  1, 16'd0, 16'd0);
        tick(0,0,0,0,8'h00,0,0, 1,1, 32'h4,  1, 16'd1, 16'd0);
        tick(0,0,0,0,8'h00,0,0, 1,1, 32'h8,  1, 16'd2, 16'd0);
        tick(0,0,0,0,8'h00,0,0, 1,1, 32'hC,  1, 16'd3, 16'd0);

        // Jump backwards, untaken branch, jump+branch together
        tick(0,1,0,0,8'h04,0,0, 1,1, 32'h20, 1, 16'd4, 16'd0);
        tick(0,1,0,0,8'hFE,0,0, 1,1, 32'h1C, 1, 16'd5, 16'd0);
        tick(0,0,0,0,8'h00,0,0, 1,1, 32'h20, 1, 16'd6, 16'd0);
        tick(0,0,1,0,8'hFE,0,0, 1,1, 32'h24, 1, 16'd7, 16'd0);
        tick(0,1,1,0,8'hFE,0,0, 1,1, 32'h20, 1, 16'd8, 16'd0);
        tick(0,1,0,0,8'h07,0,0, 1,1, 32'h40, 1, 16'd9, 16'd0);

        // Instruction stall; control inputs ignored while ibusy
        tick(0,0,0,0,8'h00,1,0, 1,0, 32'h40, 1, 16'd9, 16'd0);
        tick(0,1,0,0,8'h10,1,0, 1,0, 32'h40, 1, 16'd9, 16'd1);
        tick(0,1,0,0,8'h10,1,0, 1,0, 32'h40, 1, 16'd9, 16'd2);
        tick(0,1,0,0,8'h10,0,0, 1,0, 32'h40, 1, 16'd9, 16'd3);
        tick(0,0,0,0,8'h00,0,0, 1,1, 32'h44, 1, 16'd10, 16'd3);

        // Data stall with taken branch resolved at exit
        tick(0,1,0,0,8'hF2,0,0, 1,1, 32'h10, 1, 16'd11, 16'd3);
        tick(0,0,1,1,8'h03,0,1, 1,0, 32'h10, 0, 16'd11, 16'd3);
        tick(0,0,1,1,8'h03,0,1, 1,0, 32'h10, 0, 16'd11, 16'd4);
        tick(0,0,1,1,8'h03,0,0, 1,1, 32'h20, 1, 16'd12, 16'd5);
        tick(0,0,0,0,8'h00,0,0, 1,1, 32'h24, 1, 16'd13, 16'd5);

        // Both busy: data stall wins; reset during the stall
        tick(0,1,0,0,8'h16,0,0, 1,1, 32'h80, 1, 16'd14, 16'd5);
        tick(0,0,0,0,8'h00,1,1, 1,0, 32'h80, 0, 16'd14, 16'd5);
        tick(0,0,0,0,8'h00,1,1, 1,0, 32'h80, 0, 16'd14, 16'd6);
        tick(1,0,0,0,8'h00,0,1, 1,0, 32'h0,  0, 16'd0,  16'd0);
        tick(0,0,0,0,8'h00,0,0, 1,0, 32'h0,  1, 16'd0,  16'd0);

        // Address wrap-around
        tick(0,1,0,0,8'hFE,0,0, 1,1, 32'hFFFF_FFFC, 1, 16'd1, 16'd0);
        tick(0,0,0,0,8'h00,0,0, 1,1, 32'h0,  1, 16'd2, 16'd0);

        // Stall counter saturation
        ibusy = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("stalls_sat", 32'(stalls), 32'h0000_FFFF);
        tick(0,0,0,0,8'h00,1,0, 1,0, 32'h0,  1, 16'd2, 16'hFFFF);
        tick(0,0,0,0,8'h00,0,0, 1,0, 32'h0,  1, 16'd2, 16'hFFFF);
        tick(0,0,0,0,8'h00,0,0, 1,1, 32'h4,  1, 16'd3, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
